poly_piano: RTL and testbench

- Polyphonic successor to the single-note UART piano in z1top.
- Accepts ASCII key bytes from the on-chip UART receiver through a ready/valid handshake.
- Maps each key to an NCO frequency control word (FCW) and plays it on one of N_VOICES voices for a programmable duration.
- Echoes every accepted byte to the UART transmitter.
- Per-voice FCWs feed N NCO/DAC channels that are summed downstream.

---
 rtl/poly_piano_pkg.sv | 27 ++
 rtl/poly_piano_if.sv | 18 +
 rtl/piano_scale_rom.sv | 10 +
 rtl/poly_piano.sv | 105 ++++++++++
 tb/tb_poly_piano.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/poly_piano_pkg.sv
// poly_piano_pkg: shared widths, key-to-FCW scale table and lookup helper
package poly_piano_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int FCW_WIDTH = 24;
  typedef logic [FCW_WIDTH-1:0] fcw_t;
  typedef struct packed {
    logic hit;
    fcw_t fcw;
  } key_entry_t;
  // chromatic scale from C4 for 'a'..'z'; uppercase plays one octave higher
  localparam fcw_t SCALE [26] = '{
    24'd35,  24'd37,  24'd39,  24'd42,  24'd44,  24'd47,  24'd50,  24'd53,
    24'd56,  24'd59,  24'd63,  24'd66,  24'd70,  24'd74,  24'd79,  24'd84,
    24'd88,  24'd94,  24'd99,  24'd105, 24'd111, 24'd118, 24'd125, 24'd133,
    24'd140, 24'd149
  };
  function automatic key_entry_t key_lookup(input logic [KEY_WIDTH-1:0] key);
    key_entry_t e;
    logic [KEY_WIDTH-1:0] lo, up;
    lo = key - 8'h61;
    up = key - 8'h41;
    e = '0;
    if (lo < 8'd26) e = '{hit: 1'b1, fcw: SCALE[lo[4:0]]};
    else if (up < 8'd26) e = '{hit: 1'b1, fcw: SCALE[up[4:0]] << 1};
    return e;
  endfunction
endpackage

// File: rtl/poly_piano_if.sv
// poly_piano_if: UART receive/echo ready-valid bundle
interface poly_piano_if;
  import poly_piano_pkg::*;
  logic [KEY_WIDTH-1:0] ua_rx_data;
  logic ua_rx_valid;
  logic ua_rx_ready;
  logic [KEY_WIDTH-1:0] ua_tx_data;
  logic ua_tx_valid;
  logic ua_tx_ready;
  modport master (
    output ua_rx_data, ua_rx_valid, ua_tx_ready,
    input  ua_rx_ready, ua_tx_data, ua_tx_valid
  );
  modport slave (
    input  ua_rx_data, ua_rx_valid, ua_tx_ready,
    output ua_rx_ready, ua_tx_data, ua_tx_valid
  );
endinterface

// File: rtl/piano_scale_rom.sv
// piano_scale_rom: combinational key byte to {hit, fcw} lookup
module piano_scale_rom
  import poly_piano_pkg::*;
(
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 hit,
  output fcw_t                 fcw
);
  assign {hit, fcw} = key_lookup(key);
endmodule

// File: rtl/poly_piano.sv
// poly_piano: UART-driven polyphonic note allocator with echo buffer and
// per-voice timed FCW outputs
module poly_piano
  import poly_piano_pkg::*;
#(
  parameter int CYCLES_PER_SECOND = 125_000_000,
  parameter int N_VOICES          = 4,
  parameter int FCW_WIDTH         = 24,
  parameter int LEN_WIDTH         = 32,
  parameter int LEN_DEFAULT       = CYCLES_PER_SECOND / 5,
  parameter int LEN_STEP          = CYCLES_PER_SECOND / 20,
  parameter int LEN_MIN           = LEN_STEP,
  parameter int LEN_MAX           = 2 * CYCLES_PER_SECOND
) (
  input  logic                          clk,
  input  logic                          reset,
  poly_piano_if.slave                   uart,
  input  logic                          length_inc,
  input  logic                          length_dec,
  input  logic                          sustain,
  output logic [N_VOICES*FCW_WIDTH-1:0] fcw,
  output logic [N_VOICES-1:0]           voice_active,
  output logic [LEN_WIDTH-1:0]          note_length
);
  localparam int IW = N_VOICES > 1 ? $clog2(N_VOICES) : 1;
  localparam logic [LEN_WIDTH-1:0] L_DEF  = LEN_WIDTH'(LEN_DEFAULT);
  localparam logic [LEN_WIDTH-1:0] L_STEP = LEN_WIDTH'(LEN_STEP);
  localparam logic [LEN_WIDTH-1:0] L_MIN  = LEN_WIDTH'(LEN_MIN);
  localparam logic [LEN_WIDTH-1:0] L_MAX  = LEN_WIDTH'(LEN_MAX);
  logic                 echo_full;
  logic [KEY_WIDTH-1:0] echo_data;
  logic                 accept, load, steal, rom_hit;
  fcw_t                 rom_fcw;
  logic [N_VOICES-1:0]  active, match;
  logic [FCW_WIDTH-1:0] voice_fcw [N_VOICES];
  logic [LEN_WIDTH-1:0] timer [N_VOICES];
  logic [KEY_WIDTH-1:0] tag [N_VOICES];
  logic [IW-1:0]        steal_ptr, sel, match_idx, free_idx;
  assign uart.ua_rx_ready = !echo_full;
  assign uart.ua_tx_valid = echo_full;
  assign uart.ua_tx_data  = echo_data;
  assign accept = uart.ua_rx_valid && !echo_full;
  assign load   = accept && rom_hit;
  piano_scale_rom u_rom (
    .key(uart.ua_rx_data),
    .hit(rom_hit),
    .fcw(rom_fcw)
  );
  // descending scan so the lowest matching/free index wins
  always_comb begin
    match     = '0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      match[i]  = active[i] && tag[i] == uart.ua_rx_data;
      match_idx = match[i] ? IW'(i) : match_idx;
      free_idx  = active[i] ? free_idx : IW'(i);
    end
    steal = !(|match) && &active;
    sel   = |match ? match_idx : steal ? steal_ptr : free_idx;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      echo_full   <= 1'b0;
      echo_data   <= '0;
      steal_ptr   <= '0;
      note_length <= L_DEF;
      active      <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        voice_fcw[i] <= '0;
        timer[i]     <= '0;
        tag[i]       <= '0;
      end
    end else begin
      if (accept) begin
        echo_full <= 1'b1;
        echo_data <= uart.ua_rx_data;
      end else if (uart.ua_tx_ready) echo_full <= 1'b0;
      if (load && steal) steal_ptr <= steal_ptr == IW'(N_VOICES - 1) ? '0 : steal_ptr + 1'b1;
      if (length_inc && !length_dec)
        note_length <= note_length > L_MAX - L_STEP ? L_MAX : note_length + L_STEP;
      else if (length_dec && !length_inc)
        note_length <= note_length < L_MIN + L_STEP ? L_MIN : note_length - L_STEP;
      // a load on the expiring edge overrides the expiry
      for (int i = 0; i < N_VOICES; i++) begin
        if (load && sel == IW'(i)) begin
          active[i]    <= 1'b1;
          tag[i]       <= uart.ua_rx_data;
          voice_fcw[i] <= FCW_WIDTH'(rom_fcw);
          timer[i]     <= note_length;
        end else if (active[i] && !sustain) begin
          timer[i] <= timer[i] - 1'b1;
          if (timer[i] == LEN_WIDTH'(1)) begin
            active[i]    <= 1'b0;
            voice_fcw[i] <= '0;
          end
        end
      end
    end
  end
  for (genvar g = 0; g < N_VOICES; g++) begin : g_out
    assign fcw[g*FCW_WIDTH +: FCW_WIDTH] = voice_fcw[g];
  end
  assign voice_active = active;
endmodule

// File: tb/tb_poly_piano.sv
// tb_poly_piano: directed and random stimulus against a play-time based reference model
module tb_poly_piano;
  import poly_piano_pkg::*;
  localparam int NV = 2, LD = 20, LS = 5, LMIN = 5, LMAX = 40;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic length_inc = 1'b0, length_dec = 1'b0, sustain = 1'b0;
  logic [NV*24-1:0] fcw;
  logic [NV-1:0] voice_active;
  logic [31:0] note_length;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  poly_piano_if uart ();
  poly_piano #(.N_VOICES(NV), .LEN_DEFAULT(LD), .LEN_STEP(LS), .LEN_MIN(LMIN), .LEN_MAX(LMAX)) dut (
    .clk(clk), .reset(reset), .uart(uart), .length_inc(length_inc), .length_dec(length_dec),
    .sustain(sustain), .fcw(fcw), .voice_active(voice_active), .note_length(note_length)
  );
  // model: a voice is playing while the sustain-gated play clock is below its end time
  bit m_full;
  logic [7:0] m_echo;
  int m_nl, m_ptr;
  longint play;
  longint m_end [NV];
  logic [7:0] m_key [NV];
  logic [23:0] m_fcw [NV];
  function automatic bit m_act(int i);
    return play < m_end[i];
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    key_entry_t e;
    bit acc;
    int sel;
    longint pn;
    acc = uart.ua_rx_valid && !m_full && reset;
    e = key_lookup(uart.ua_rx_data);
    if (!reset) begin
      m_full = 0; m_echo = 0; m_nl = LD; m_ptr = 0; play = 0;
      for (int i = 0; i < NV; i++) begin m_end[i] = 0; m_key[i] = 0; m_fcw[i] = 0; end
    end else begin
      pn = play + (sustain ? 0 : 1);
      if (acc && e.hit) begin
        sel = -1;
        for (int i = 0; i < NV; i++) if (sel < 0 && m_act(i) && m_key[i] == uart.ua_rx_data) sel = i;
        for (int i = 0; i < NV; i++) if (sel < 0 && !m_act(i)) sel = i;
        if (sel < 0) begin sel = m_ptr; m_ptr = (m_ptr + 1) % NV; end
        m_key[sel] = uart.ua_rx_data; m_fcw[sel] = e.fcw; m_end[sel] = pn + m_nl;
      end
      if (length_inc && !length_dec) m_nl = (m_nl + LS > LMAX) ? LMAX : m_nl + LS;
      else if (length_dec && !length_inc) m_nl = (m_nl - LS < LMIN) ? LMIN : m_nl - LS;
      if (acc) begin m_full = 1; m_echo = uart.ua_rx_data; end
      else if (uart.ua_tx_ready) m_full = 0;
      play = pn;
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      chk("voice_active", voice_active[i], m_act(i));
      chk("fcw", fcw[i*24 +: 24], m_act(i) ? m_fcw[i] : 24'd0);
    end
    chk("rx_ready", uart.ua_rx_ready, !m_full);
    chk("tx_valid", uart.ua_tx_valid, m_full);
    chk("tx_data", uart.ua_tx_data, m_echo);
    chk("note_length", note_length, m_nl);
  endtask
  task automatic send(logic [7:0] b);
    bit got = 0;
    uart.ua_rx_data = b;
    uart.ua_rx_valid = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      got = uart.ua_rx_ready;
      step();
    end
    uart.ua_rx_valid = 1'b0;
    chk("send_accept", got, 1'b1);
  endtask
  task automatic wait_n(int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic pulse(bit inc, bit dec);
    length_inc = inc; length_dec = dec;
    step();
    length_inc = 0; length_dec = 0;
  endtask
  logic [7:0] keys [7] = '{"a", "b", "c", "A", "z", "1", " "};
  initial begin
    uart.ua_rx_data = 0; uart.ua_rx_valid = 0; uart.ua_tx_ready = 1;
    @(negedge clk);
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_len", note_length, 32'd20);
    chk("rst_active", voice_active, 2'b00);
    chk("rst_rx_ready", uart.ua_rx_ready, 1'b1);
    chk("rst_tx_valid", uart.ua_tx_valid, 1'b0);
    send("z");
    chk("z_active", voice_active, 2'b01);
    chk("z_fcw", fcw[23:0], key_lookup("z").fcw);
    chk("z_echo", {uart.ua_tx_valid, uart.ua_tx_data}, 9'h17a);
    wait_n(19);
    chk("z_hold", voice_active[0], 1'b1);
    step();
    chk("z_expire", voice_active[0], 1'b0);
    send("a"); send("b"); send("c");
    chk("steal_active", voice_active, 2'b11);
    chk("steal_v0", fcw[23:0], key_lookup("c").fcw);
    chk("steal_v1", fcw[47:24], key_lookup("b").fcw);
    send("d");
    chk("steal_ptr_v1", fcw[47:24], key_lookup("d").fcw);
    wait_n(25);
    send("a");
    wait_n(10);
    send("a");
    chk("retrig_single", voice_active, 2'b01);
    wait_n(19);
    chk("retrig_hold", voice_active[0], 1'b1);
    step();
    chk("retrig_expire", voice_active[0], 1'b0);
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    chk("len_35", note_length, 32'd35);
    send("1");
    chk("nohit_echo", uart.ua_tx_data, 8'h31);
    chk("nohit_idle", voice_active, 2'b00);
    send("q");
    wait_n(34);
    chk("q_hold", voice_active[0], 1'b1);
    step();
    chk("q_expire", voice_active[0], 1'b0);
    pulse(1, 1);
    chk("len_both", note_length, 32'd35);
    pulse(1, 0); pulse(1, 0);
    chk("len_max", note_length, 32'd40);
    for (int k = 0; k < 10; k++) pulse(0, 1);
    chk("len_min", note_length, 32'd5);
    uart.ua_tx_ready = 0;
    send("e");
    uart.ua_rx_data = "f"; uart.ua_rx_valid = 1;
    wait_n(3);
    chk("stall_ready", uart.ua_rx_ready, 1'b0);
    chk("stall_data", uart.ua_tx_data, 8'h65);
    uart.ua_tx_ready = 1;
    step();
    chk("drain_ready", uart.ua_rx_ready, 1'b1);
    step();
    uart.ua_rx_valid = 0;
    chk("second_echo", uart.ua_tx_data, 8'h66);
    wait_n(10);
    pulse(1, 0); pulse(1, 0);
    send("g");
    wait_n(3);
    sustain = 1;
    wait_n(50);
    chk("sustain_hold", voice_active[0], 1'b1);
    sustain = 0;
    wait_n(2);
    reset = 0;
    step();
    reset = 1;
    chk("reset_active", voice_active, 2'b00);
    chk("reset_fcw", fcw, '0);
    chk("reset_len", note_length, 32'd20);
    for (int k = 0; k < 3000; k++) begin
      uart.ua_rx_valid = 1'($urandom_range(0, 1));
      uart.ua_rx_data = keys[$urandom_range(0, 6)];
      uart.ua_tx_ready = ($urandom % 4) != 0;
      if ($urandom % 16 == 0) sustain = ~sustain;
      length_inc = ($urandom % 16) == 0;
      length_dec = ($urandom % 16) == 0;
      reset = ($urandom % 500) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
